load_counter: RTL and testbench

Programmable period counter for the ADPLL loop: the load-side counterpart of the counter-capture stage. It accepts a signed count value on a rising edge of a load strobe and counts toward zero on enabled ticks. On reaching zero it emits a one-cycle expiry pulse and toggles a divided output. In reload mode it restarts from the last loaded value, so it can serve as the programmable divider / DCO period generator feeding the phase detector.

---
 rtl/adpll_pkg.sv | 11 +
 rtl/pulse_on_pos_edge_sr.sv | 22 ++
 rtl/load_counter.sv | 93 +++++++++
 tb/tb_load_counter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: counter FSM state encoding and default counter width.
package adpll_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } cnt_state_t;

    localparam int ADPLL_CNT_WIDTH = 20;

endpackage

// File: rtl/pulse_on_pos_edge_sr.sv
// Rising-edge pulse generator; the history register resets to 1 so a level held
// high across reset is not mistaken for a fresh edge.
module pulse_on_pos_edge_sr (
    input  logic fpga_clk_i,
    input  logic reset_i,
    input  logic sig_i,
    output logic pulse_o
);

    logic sig_q;

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            sig_q <= 1'b1;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign pulse_o = sig_i & ~sig_q;

endmodule

// File: rtl/load_counter.sv
// Programmable period counter for the ADPLL: loads a signed value on a load edge,
// counts toward zero on enabled ticks, pulses and toggles on expiry, optionally reloads.
module load_counter
    import adpll_pkg::*;
#(
    parameter int WIDTH = ADPLL_CNT_WIDTH
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_i,
    input  logic                    load_i,
    input  logic signed [WIDTH-1:0] load_val_i,
    input  logic                    count_en_i,
    input  logic                    reload_en_i,
    output logic signed [WIDTH-1:0] counter_val_o,
    output logic                    busy_o,
    output logic                    expire_o,
    output logic                    toggle_o
);

    cnt_state_t              state_q;
    cnt_state_t              state_d;
    logic signed [WIDTH-1:0] counter_d;
    logic signed [WIDTH-1:0] reload_q;
    logic signed [WIDTH-1:0] reload_d;
    logic                    expire_d;
    logic                    toggle_d;
    logic                    load_x;
    logic                    at_unit;

    pulse_on_pos_edge_sr u_load_edge (
        .fpga_clk_i (fpga_clk_i),
        .reset_i    (reset_i),
        .sig_i      (load_i),
        .pulse_o    (load_x)
    );

    // One tick away from zero in either direction means this tick is the expiry.
    assign at_unit = (counter_val_o == WIDTH'(1)) || (counter_val_o == {WIDTH{1'b1}});

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            counter_val_o <= '0;
            reload_q      <= '0;
            expire_o      <= 1'b0;
            toggle_o      <= 1'b0;
        end else begin
            state_q       <= state_d;
            counter_val_o <= counter_d;
            reload_q      <= reload_d;
            expire_o      <= expire_d;
            toggle_o      <= toggle_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_val_o;
        reload_d  = reload_q;
        expire_d  = 1'b0;
        toggle_d  = toggle_o;

        if (load_x) begin
            // A zero load is a clear: it stops the counter but keeps the old reload value.
            if (load_val_i != '0) begin
                counter_d = load_val_i;
                reload_d  = load_val_i;
                state_d   = ST_COUNT;
            end else begin
                counter_d = '0;
                state_d   = ST_IDLE;
            end
        end else if ((state_q == ST_COUNT) && count_en_i) begin
            if (at_unit) begin
                expire_d = 1'b1;
                toggle_d = ~toggle_o;
                if (reload_en_i) begin
                    counter_d = reload_q;
                end else begin
                    counter_d = '0;
                    state_d   = ST_IDLE;
                end
            end else if (counter_val_o[WIDTH-1]) begin
                counter_d = counter_val_o + WIDTH'(1);
            end else begin
                counter_d = counter_val_o - WIDTH'(1);
            end
        end
    end

    assign busy_o = (state_q == ST_COUNT);

endmodule

// File: tb/tb_load_counter.sv
// Randomized and directed bench for load_counter against an integer reference model.
// A narrower counter keeps the full-range expiry run short.
module tb_load_counter;

    localparam int W   = 16;
    localparam int MIN = -(1 << (W - 1));

    logic                fpga_clk_i = 1'b0;
    logic                reset_i = 1'b1;
    logic                load_i = 1'b1;
    logic signed [W-1:0] load_val_i = '0;
    logic                count_en_i = 1'b0;
    logic                reload_en_i = 1'b0;
    logic signed [W-1:0] counter_val_o;
    logic                busy_o;
    logic                expire_o;
    logic                toggle_o;

    int total = 0;
    int bad = 0;
    bit check_on = 1'b0;

    int m_cnt = 0;
    int m_reload = 0;
    bit m_busy = 1'b0;
    bit m_exp = 1'b0;
    bit m_tog = 1'b0;
    bit m_loadq = 1'b1;

    load_counter #(.WIDTH(W)) dut (
        .fpga_clk_i    (fpga_clk_i),
        .reset_i       (reset_i),
        .load_i        (load_i),
        .load_val_i    (load_val_i),
        .count_en_i    (count_en_i),
        .reload_en_i   (reload_en_i),
        .counter_val_o (counter_val_o),
        .busy_o        (busy_o),
        .expire_o      (expire_o),
        .toggle_o      (toggle_o)
    );

    always #5 fpga_clk_i = ~fpga_clk_i;

    task automatic check_output(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts the magnitude toward zero and looks at where it lands.
    always @(posedge fpga_clk_i) begin
        int v;
        int nxt;
        bit edge_seen;
        if (reset_i) begin
            m_cnt = 0; m_reload = 0; m_busy = 0; m_exp = 0; m_tog = 0; m_loadq = 1;
        end else begin
            edge_seen = load_i && !m_loadq;
            m_loadq = load_i;
            m_exp = 0;
            v = load_val_i;
            if (edge_seen) begin
                m_cnt = v;
                m_busy = (v != 0);
                if (v != 0) m_reload = v;
            end else if (m_busy && count_en_i) begin
                nxt = (m_cnt > 0) ? m_cnt - 1 : m_cnt + 1;
                if (nxt == 0) begin
                    m_exp = 1;
                    m_tog = !m_tog;
                    if (reload_en_i) m_cnt = m_reload;
                    else begin
                        m_cnt = 0;
                        m_busy = 0;
                    end
                end else begin
                    m_cnt = nxt;
                end
            end
        end
    end

    always @(negedge fpga_clk_i) begin
        if (check_on) begin
            check_output("model_count", int'(counter_val_o), m_cnt);
            check_output("model_busy", int'(busy_o), int'(m_busy));
            check_output("model_expire", int'(expire_o), int'(m_exp));
            check_output("model_toggle", int'(toggle_o), int'(m_tog));
        end
    end

    // Inputs change on the falling edge; outputs are inspected one falling edge later.
    task automatic apply_stimulus(input bit rst, input bit ld, input int val,
                                  input bit en, input bit rel);
        reset_i     = rst;
        load_i      = ld;
        load_val_i  = W'(val);
        count_en_i  = en;
        reload_en_i = rel;
        @(posedge fpga_clk_i);
        @(negedge fpga_clk_i);
    endtask

    initial begin
        int n;
        int exps;
        int r;

        repeat (3) apply_stimulus(1, 1, 0, 0, 0);
        check_on = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(0, 1, 7, 1, 0);
            check_output("held_load_busy", int'(busy_o), 0);
            check_output("held_load_count", int'(counter_val_o), 0);
        end
        apply_stimulus(0, 0, 0, 1, 0);

        apply_stimulus(0, 1, 3, 1, 0);
        check_output("pos3_load", int'(counter_val_o), 3);
        apply_stimulus(0, 0, 0, 1, 0);
        check_output("pos3_step2", int'(counter_val_o), 2);
        apply_stimulus(0, 0, 0, 1, 0);
        check_output("pos3_step1", int'(counter_val_o), 1);
        check_output("pos3_noexp", int'(expire_o), 0);
        apply_stimulus(0, 0, 0, 1, 0);
        check_output("pos3_zero", int'(counter_val_o), 0);
        check_output("pos3_expire", int'(expire_o), 1);
        check_output("pos3_busy", int'(busy_o), 0);
        check_output("pos3_toggle", int'(toggle_o), 1);
        apply_stimulus(0, 0, 0, 1, 0);
        check_output("pos3_pulse_end", int'(expire_o), 0);

        apply_stimulus(0, 1, -4, 1, 1);
        check_output("neg4_load", int'(counter_val_o), -4);
        exps = 0;
        for (int i = 1; i <= 12; i++) begin
            apply_stimulus(0, 0, 0, 1, 1);
            if (expire_o) exps++;
            check_output("neg4_seq", int'(counter_val_o), (i % 4 == 0) ? -4 : -4 + (i % 4));
        end
        check_output("neg4_expiries", exps, 3);
        check_output("neg4_toggle", int'(toggle_o), 0);

        apply_stimulus(0, 1, 2, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0);
        check_output("gate_tick1", int'(counter_val_o), 1);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("gate_hold", int'(counter_val_o), 1);
        apply_stimulus(0, 0, 0, 1, 0);
        check_output("gate_expire", int'(expire_o), 1);

        apply_stimulus(0, 1, 5, 1, 0);
        repeat (4) apply_stimulus(0, 0, 0, 1, 0);
        check_output("preempt_at1", int'(counter_val_o), 1);
        apply_stimulus(0, 1, 1, 1, 0);
        check_output("preempt_noexp", int'(expire_o), 0);
        check_output("preempt_count", int'(counter_val_o), 1);
        apply_stimulus(0, 0, 0, 1, 1);
        check_output("reload_reg1", int'(counter_val_o), 1);
        check_output("reload_reg1_exp", int'(expire_o), 1);
        apply_stimulus(0, 1, 0, 1, 1);
        check_output("clear_count", int'(counter_val_o), 0);
        check_output("clear_busy", int'(busy_o), 0);
        check_output("clear_noexp", int'(expire_o), 0);
        apply_stimulus(0, 0, 0, 0, 0);

        apply_stimulus(0, 1, MIN, 1, 0);
        check_output("min_load", int'(counter_val_o), MIN);
        n = 0;
        while (n < 40000) begin
            apply_stimulus(0, 0, 0, 1, 0);
            n++;
            if (expire_o) break;
        end
        check_output("min_period", n, 32768);
        apply_stimulus(0, 1, MIN, 1, 0);
        repeat (10) apply_stimulus(0, 0, 0, 1, 0);
        apply_stimulus(1, 0, 0, 1, 0);
        check_output("rst_count", int'(counter_val_o), 0);
        check_output("rst_busy", int'(busy_o), 0);
        check_output("rst_expire", int'(expire_o), 0);
        check_output("rst_toggle", int'(toggle_o), 0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) r = int'($urandom);
            else r = int'($urandom_range(0, 12)) - 6;
            apply_stimulus($urandom_range(0, 499) == 0, $urandom_range(0, 7) == 0, r,
                           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
